// File: rtl/tone_capture_pkg.sv
//==============================================================================
// tone_capture_pkg : shared state type and default timing constants
// Rev 1.0
//==============================================================================
`default_nettype none

package tone_capture_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int SIM_TIMEOUT = 40;
    localparam int DEF_TIMEOUT = 8000;
    localparam int DEF_TOL     = 4;

endpackage

`default_nettype wire

// File: rtl/tone_capture_sync_edge_det.sv
//==============================================================================
// sync_edge_det : 2-flop synchronizer plus a third flop for any-edge strobe
// Rev 1.0
//==============================================================================
`default_nettype none

module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic strobe
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign strobe = sync ^ prev;

endmodule

`default_nettype wire

// File: rtl/tone_capture.sv
//==============================================================================
// tone_capture : detects a square-wave burst, measures half-period and cycles
// Rev 1.0
//==============================================================================
`default_nettype none

module tone_capture
    import tone_capture_pkg::*;
#(
    parameter int simulation = 0,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int TOL        = DEF_TOL,
    parameter int HP_W       = 12
) (
    input  logic            clk_4M_i,
    input  logic            rst_i,
    input  logic            pin_i,
    input  logic            ack_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [HP_W-1:0] half_period_o,
    output logic [31:0]     cycles_o,
    output logic            jitter_o,
    output logic            overrun_o
);

    localparam int EFF_TO = (simulation != 0) ? SIM_TIMEOUT : TIMEOUT;
    localparam int TO_BITS = $clog2(EFF_TO + 1);
    // Tick counter is wide enough for both the timeout and the half-period range.
    localparam int TW = ((TO_BITS > HP_W) ? TO_BITS : HP_W) + 1;

    localparam logic [TW-1:0] TICK_MAX = {TW{1'b1}};
    localparam logic [TW-1:0] TO_LAST  = TW'(EFF_TO - 1);
    localparam logic [TW:0]   HP_MAX_X = {{(TW + 1 - HP_W){1'b0}}, {HP_W{1'b1}}};
    localparam logic [TW:0]   TOL_X    = (TW + 1)'(TOL);

    state_t          state;
    state_t          state_nxt;
    logic            edge_stb;
    logic [TW-1:0]   tick_cnt;
    logic [31:0]     edge_cnt;
    logic [HP_W-1:0] hp_lat;
    logic            hp_seen;
    logic            jitter;
    logic            overrun;
    logic [HP_W-1:0] hp_rep;
    logic [31:0]     cyc_rep;
    logic            jit_rep;

    logic [TW:0]     interval;
    logic [TW:0]     hp_lat_x;
    logic [TW:0]     abs_diff;
    logic [HP_W-1:0] hp_sat;
    logic            too_far;
    logic            timeout;

    sync_edge_det u_sync (
        .clk    (clk_4M_i),
        .rst    (rst_i),
        .din    (pin_i),
        .strobe (edge_stb)
    );

    assign interval = {1'b0, tick_cnt} + 1'b1;
    assign hp_lat_x = {{(TW + 1 - HP_W){1'b0}}, hp_lat};
    assign abs_diff = (interval >= hp_lat_x) ? (interval - hp_lat_x) : (hp_lat_x - interval);
    assign too_far  = abs_diff > TOL_X;
    assign hp_sat   = (interval > HP_MAX_X) ? {HP_W{1'b1}} : interval[HP_W-1:0];
    assign timeout  = (tick_cnt == TO_LAST) && !edge_stb;

    always_ff @(posedge clk_4M_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (edge_stb) state_nxt = ACTIVE;
            ACTIVE:  if (timeout)  state_nxt = (edge_cnt >= 32'd2) ? REPORT : IDLE;
            REPORT:  if (ack_i)    state_nxt = edge_stb ? ACTIVE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state == ACTIVE);
        valid_o = (state == REPORT);
    end

    always_ff @(posedge clk_4M_i) begin
        if (rst_i) begin
            tick_cnt <= '0;
            edge_cnt <= '0;
            hp_lat   <= '0;
            hp_seen  <= 1'b0;
            jitter   <= 1'b0;
            overrun  <= 1'b0;
            hp_rep   <= '0;
            cyc_rep  <= '0;
            jit_rep  <= 1'b0;
        end else begin
            if (edge_stb)                  tick_cnt <= '0;
            else if (tick_cnt != TICK_MAX) tick_cnt <= tick_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (edge_stb) begin
                        edge_cnt <= 32'd1;
                        jitter   <= 1'b0;
                        hp_seen  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (edge_stb) begin
                        if (edge_cnt != 32'hFFFF_FFFF) edge_cnt <= edge_cnt + 32'd1;
                        if (!hp_seen) begin
                            hp_lat  <= hp_sat;
                            hp_seen <= 1'b1;
                        end else if (too_far) begin
                            jitter <= 1'b1;
                        end
                    end else if (timeout && (edge_cnt >= 32'd2)) begin
                        hp_rep  <= hp_lat;
                        cyc_rep <= edge_cnt >> 1;
                        jit_rep <= jitter;
                    end
                end
                REPORT: begin
                    // Ack beats a coincident edge: that edge opens the next capture.
                    if (ack_i && edge_stb) begin
                        edge_cnt <= 32'd1;
                        jitter   <= 1'b0;
                        hp_seen  <= 1'b0;
                    end else if (edge_stb) begin
                        overrun <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign half_period_o = hp_rep;
    assign cycles_o      = cyc_rep;
    assign jitter_o      = jit_rep;
    assign overrun_o     = overrun;

endmodule

`default_nettype wire

// File: doc/tone_capture.md
Name: tone_capture

Overview:
- Receive-side counterpart of the buzzer driver.
- Samples an external square-wave line and detects a tone burst. Measures its half-period in clk_4M_i ticks and counts its full cycles.
- Reports the result through a valid/ack handshake.
- Sits beside the buzzer in loopback/self-test builds and on the audio-sense input.

Parameters:
simulation, 0, 1 selects short timeout (40 ticks) for simulation; 0 uses TIMEOUT
TIMEOUT, 8000, silence in clk_4M_i ticks after the last edge that ends a burst (2 ms at 4 MHz); must exceed the largest expected half-period
TOL, 4, maximum allowed deviation in ticks of any later half-period from the first one
HP_W, 12, width of the half-period counter/output

Ports:
clk_4M_i  in  1  4 MHz clock; single clock domain
rst_i  in  1  reset, synchronous, active-high
pin_i  in  1  asynchronous tone input
ack_i  in  1  consumer acknowledges the held report
busy_o  out  1  high while a burst is being captured (ACTIVE)
valid_o  out  1  report available; held until ack_i
half_period_o  out  HP_W  first measured half-period in ticks, saturating at 2^HP_W-1
cycles_o  out  32  full cycles in burst = edges/2 (floor), saturating
jitter_o  out  1  some half-period deviated from the first by more than TOL
overrun_o  out  1  sticky: a burst began while the report was unacknowledged

Behaviour:
- Synchronous reset takes effect on the next clk_4M_i edge.
  - All outputs 0; state IDLE; counters 0; synchronizer flops 0.
  - Reset mid-burst or mid-report discards everything.
- Input path: 2-flop synchronizer, then a third flop for edge detect.
  - Edge strobe = sync2 XOR sync3; either polarity counts.
  - Strobe fires 3 clocks after a pin_i change. The offset is common to all edges, so intervals are exact.
- Counters:
  - tick_cnt counts clocks since the last edge; it clears on each edge and saturates.
  - edge_cnt is 32 bits and saturates.
- State IDLE:
  - On an edge strobe: go to ACTIVE, clear tick_cnt, set edge_cnt=1, clear jitter and half-period-valid.
- State ACTIVE (busy_o=1):
  - Each edge: edge_cnt++, tick_cnt cleared.
  - Second edge: half_period latched = tick_cnt+1, saturating at 2^HP_W-1.
  - Later edges: compare (tick_cnt+1) with the latched value; |diff|>TOL sets jitter.
  - Timeout: tick_cnt reaching effective timeout-1 with no edge (effective timeout = 40 if simulation else TIMEOUT).
    - edge_cnt>=2: go to REPORT. valid_o=1 in the next cycle; cycles_o=edge_cnt>>1; half_period_o and jitter_o driven from the latched values.
    - edge_cnt==1 (single glitch): return to IDLE silently, no report.
- State REPORT (valid_o=1):
  - Output data is stable until ack_i.
  - ack_i: valid_o drops next cycle; go to IDLE.
  - Edge without ack_i: set overrun_o and stay in REPORT. The rest of that burst is lost; after ack, capture restarts at the next edge.
  - ack_i and edge in the same cycle: ack wins, valid_o drops, and that edge starts a new capture (go directly to ACTIVE with edge_cnt=1).
- overrun_o clears only on reset.
- Buzzer compatibility: buzzer with period_ms_i=P toggles every 2001 ticks, giving 2P edges → half_period_o=2001, cycles_o=P.

Decomposition:
- Package tone_capture_pkg holds:
  - state enum {IDLE, ACTIVE, REPORT}
  - simulation timeout constant (40)
  - default TIMEOUT and TOL
- One natural sub-module: sync_edge_det (2-flop synchronizer + edge strobe). It is reusable for other async inputs.
- Everything else lives in one module.

Test Plan:
1. simulation=0, pin_i toggles every 2001 clocks, 10 edges → 8000 clocks after the last edge strobe: valid_o=1, half_period_o=2001, cycles_o=5, jitter_o=0; busy_o low from that cycle.
2. Single pin_i transition then silence → busy_o high for 8000 clocks, then IDLE; valid_o never asserts.
3. Intervals 2001, 2001, 2010 → jitter_o=1, half_period_o=2001. Intervals 2001, 2004 → jitter_o=0 (TOL boundary).
4. Report held, ack_i low, new toggles start → overrun_o=1, half_period_o/cycles_o unchanged. ack_i pulse → valid_o=0 next cycle.
5. Assert rst_i for one cycle mid-ACTIVE (edge_cnt=6) → next cycle busy_o=0, valid_o=0, all outputs 0. A following 4-edge burst reports cycles_o=2.
6. ack_i coincident with an edge strobe in REPORT → valid_o drops, busy_o=1 next cycle. A burst of 6 edges total reports cycles_o=3.
